// File: rtl/hdmi_tx_mode_sequencer_pkg.sv
// rtl/hdmi_tx_mode_sequencer_pkg.sv - shared types and constants for the HDMI TX mode sequencer
package hdmi_tx_mode_pkg;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    WAIT_FRAME,
    WR_SET,
    HOLD,
    WR_CLR,
    WAIT_LOCK,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] MODE_PIO_ADDR = 2'd0;
  localparam logic       PIO_SET       = 1'b1;
  localparam logic       PIO_CLR       = 1'b0;

endpackage

// File: rtl/hdmi_tx_mode_sequencer_if.sv
// rtl/hdmi_tx_mode_sequencer_if.sv - Avalon-MM write port toward the mode_change PIO
interface hdmi_tx_mode_sequencer_if;

  logic [1:0] av_address;
  logic       av_chipselect;
  logic       av_write_n;
  logic       av_writedata;

  modport master (
    output av_address,
    output av_chipselect,
    output av_write_n,
    output av_writedata
  );

  modport slave (
    input av_address,
    input av_chipselect,
    input av_write_n,
    input av_writedata
  );

endinterface

// File: rtl/hdmi_tx_lock_monitor.sv
// rtl/hdmi_tx_lock_monitor.sv - consecutive-lock and timeout counters for the WAIT_LOCK phase
module hdmi_tx_lock_monitor #(
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tx_locked,
  output logic locked_ok,
  output logic timed_out
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic [SW-1:0] r_stable_cnt;
  logic [TW-1:0] r_timeout_cnt;

  // Both counters saturate so they cannot wrap while the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (!tx_locked)
        r_stable_cnt <= '0;
      else if (r_stable_cnt != SW'(LOCK_STABLE))
        r_stable_cnt <= r_stable_cnt + SW'(1);
      if (r_timeout_cnt != TW'(LOCK_TIMEOUT))
        r_timeout_cnt <= r_timeout_cnt + TW'(1);
    end
  end

  // Flags fire in the cycle whose sample makes the count reach its limit.
  assign locked_ok = tx_locked && (r_stable_cnt == SW'(LOCK_STABLE - 1));
  assign timed_out = (r_timeout_cnt == TW'(LOCK_TIMEOUT - 1));

endmodule

// File: rtl/hdmi_tx_mode_sequencer.sv
// rtl/hdmi_tx_mode_sequencer.sv - blanks video, pulses the mode_change PIO on a frame boundary,
// then waits for stable TX lock before unblanking
module hdmi_tx_mode_sequencer
  import hdmi_tx_mode_pkg::*;
#(
  parameter int MODE_W       = 4,
  parameter int PULSE_CYC    = 16,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int RESET_MODE   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [MODE_W-1:0]        req_mode,
  output logic                     req_ready,
  input  logic                     frame_start,
  input  logic                     tx_locked,
  hdmi_tx_mode_sequencer_if.master bus,
  output logic [MODE_W-1:0]        cur_mode,
  output logic                     video_blank,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);

  localparam int HW = $clog2(PULSE_CYC + 1);

  state_t            r_state;
  logic [HW-1:0]     r_hold_cnt;
  logic [MODE_W-1:0] r_req_mode;
  logic [MODE_W-1:0] r_cur_mode;
  logic              r_cs;
  logic              r_wr_n;
  logic              r_wd;
  logic              r_req_ready;
  logic              r_video_blank;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout_err;
  logic              w_clear;
  logic              w_locked_ok;
  logic              w_timed_out;

  assign w_clear = (r_state == WR_CLR);

  hdmi_tx_lock_monitor #(
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_lock_monitor (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .tx_locked (tx_locked),
    .locked_ok (w_locked_ok),
    .timed_out (w_timed_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= INIT;
      r_hold_cnt    <= '0;
      r_req_mode    <= MODE_W'(RESET_MODE);
      r_cur_mode    <= MODE_W'(RESET_MODE);
      r_cs          <= 1'b0;
      r_wr_n        <= 1'b1;
      r_wd          <= PIO_CLR;
      r_req_ready   <= 1'b0;
      r_video_blank <= 1'b0;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cs          <= 1'b0;
      r_wr_n        <= 1'b1;
      r_wd          <= PIO_CLR;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b1;
      r_req_ready   <= 1'b0;
      case (r_state)
        INIT: begin
          r_cs    <= 1'b1;
          r_wr_n  <= 1'b0;
          r_wd    <= PIO_CLR;
          r_state <= IDLE;
        end
        IDLE: begin
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_req_mode  <= req_mode;
            if (req_mode == r_cur_mode) begin
              r_done <= 1'b1;
            end else begin
              r_busy        <= 1'b1;
              r_video_blank <= 1'b1;
              r_state       <= WAIT_FRAME;
            end
          end
        end
        WAIT_FRAME: if (frame_start) r_state <= WR_SET;
        WR_SET: begin
          r_cs       <= 1'b1;
          r_wr_n     <= 1'b0;
          r_wd       <= PIO_SET;
          r_cur_mode <= r_req_mode;
          r_hold_cnt <= '0;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (r_hold_cnt == HW'(PULSE_CYC - 1))
            r_state <= WR_CLR;
          else
            r_hold_cnt <= r_hold_cnt + HW'(1);
        end
        WR_CLR: begin
          r_cs    <= 1'b1;
          r_wr_n  <= 1'b0;
          r_wd    <= PIO_CLR;
          r_state <= WAIT_LOCK;
        end
        // Lock success is checked first so it wins a same-cycle timeout.
        WAIT_LOCK: begin
          if (w_locked_ok)
            r_state <= DONE;
          else if (w_timed_out)
            r_state <= ERR;
        end
        DONE: begin
          r_done        <= 1'b1;
          r_video_blank <= 1'b0;
          r_state       <= IDLE;
        end
        ERR: begin
          r_timeout_err <= 1'b1;
          r_video_blank <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign bus.av_address    = MODE_PIO_ADDR;
  assign bus.av_chipselect = r_cs;
  assign bus.av_write_n    = r_wr_n;
  assign bus.av_writedata  = r_wd;
  assign req_ready         = r_req_ready;
  assign cur_mode          = r_cur_mode;
  assign video_blank       = r_video_blank;
  assign busy              = r_busy;
  assign done              = r_done;
  assign timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_hdmi_tx_mode_sequencer.sv
// tb/tb_hdmi_tx_mode_sequencer.sv - scoreboard bench for the HDMI TX mode sequencer
module tb_hdmi_tx_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_mode = 4'd0;
  logic       frame_start = 1'b0;
  logic       tx_locked = 1'b0;
  logic       req_ready;
  logic [3:0] cur_mode;
  logic       video_blank;
  logic       busy;
  logic       done;
  logic       timeout_err;

  hdmi_tx_mode_sequencer_if bus();

  hdmi_tx_mode_sequencer #(
    .MODE_W       (4),
    .PULSE_CYC    (4),
    .LOCK_STABLE  (3),
    .LOCK_TIMEOUT (20),
    .RESET_MODE   (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_ready   (req_ready),
    .frame_start (frame_start),
    .tx_locked   (tx_locked),
    .bus         (bus),
    .cur_mode    (cur_mode),
    .video_blank (video_blank),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags = {timeout_err, done, chipselect}
  typedef struct {
    string      name;
    logic [2:0] flags;
    logic       wd;
    int         at;
    logic [3:0] mode;
    logic       blank;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    logic [2:0] fl;
    exp_t       e;
    fl = {timeout_err, done, bus.av_chipselect};
    if (fl != 3'b000) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: flags=%b wd=%b at cycle %0d, no event required", fl, bus.av_writedata, cyc);
      end else begin
        e = sb.pop_front();
        if (fl !== e.flags || cyc != e.at || cur_mode !== e.mode || video_blank !== e.blank ||
            (bus.av_chipselect && (bus.av_write_n !== 1'b0 || bus.av_address !== 2'd0 || bus.av_writedata !== e.wd))) begin
          n_err++;
          $display("FAIL %s: flags=%b wr_n=%b addr=%0d wd=%b cyc=%0d mode=%0d blank=%b, required flags=%b wr_n=0 addr=0 wd=%b cyc=%0d mode=%0d blank=%b",
                   e.name, fl, bus.av_write_n, bus.av_address, bus.av_writedata, cyc, cur_mode, video_blank,
                   e.flags, e.wd, e.at, e.mode, e.blank);
        end
      end
    end
  end

  task automatic expect_ev(input string name, input logic [2:0] fl, input logic wd,
                           input int at, input logic [3:0] mode, input logic blank);
    exp_t e;
    e.name = name; e.flags = fl; e.wd = wd; e.at = at; e.mode = mode; e.blank = blank;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d events still pending (next %s), required 0", sb.size(), sb[0].name);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic accept(input logic [3:0] m);
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_mode  = m;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         t0;
    logic [0:5] pat;

    // Reset state and the INIT clearing write
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {23'd0, bus.av_chipselect, bus.av_write_n, bus.av_writedata, bus.av_address,
           video_blank, done, timeout_err, busy, req_ready},
          {23'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    check("reset_cur_mode", {28'd0, cur_mode}, 32'd0);
    t0 = cyc;
    expect_ev("init_clear_write", 3'b001, 1'b0, t0 + 1, 4'd0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("req_ready_cycle1", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("req_ready_cycle2", {31'd0, req_ready}, 32'd1);
    check("busy_idle", {31'd0, busy}, 32'd0);
    drain(10);

    // Mode 3, frame_start five cycles after accept, lock steady
    tx_locked = 1'b1;
    t0 = cyc;
    expect_ev("main_set_write", 3'b001, 1'b1, t0 + 7, 4'd3, 1'b1);
    expect_ev("main_clr_write", 3'b001, 1'b0, t0 + 12, 4'd3, 1'b1);
    expect_ev("main_done", 3'b010, 1'b0, t0 + 16, 4'd3, 1'b0);
    accept(4'd3);
    check("main_blank_after_accept", {31'd0, video_blank}, 32'd1);
    check("main_busy_after_accept", {31'd0, busy}, 32'd1);
    check("main_ready_drop", {31'd0, req_ready}, 32'd0);
    repeat (4) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    drain(40);

    // Same mode again: immediate done, no bus traffic, no blanking
    t0 = cyc;
    expect_ev("same_mode_done", 3'b010, 1'b0, t0 + 1, 4'd3, 1'b0);
    accept(4'd3);
    check("same_mode_ready_drop", {31'd0, req_ready}, 32'd0);
    check("same_mode_blank", {31'd0, video_blank}, 32'd0);
    @(negedge clk);
    check("same_mode_ready_back", {31'd0, req_ready}, 32'd1);
    drain(10);

    // Lock toggles 1,1,0,1,1,1 inside WAIT_LOCK
    tx_locked = 1'b0;
    t0 = cyc;
    expect_ev("toggle_set_write", 3'b001, 1'b1, t0 + 3, 4'd5, 1'b1);
    expect_ev("toggle_clr_write", 3'b001, 1'b0, t0 + 8, 4'd5, 1'b1);
    expect_ev("toggle_done", 3'b010, 1'b0, t0 + 15, 4'd5, 1'b0);
    accept(4'd5);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (6) @(negedge clk);
    pat = 6'b110111;
    for (int i = 0; i < 6; i++) begin
      tx_locked = pat[i];
      @(negedge clk);
    end
    tx_locked = 1'b0;
    drain(30);

    // frame_start on the accept cycle must be ignored
    tx_locked = 1'b1;
    t0 = cyc;
    expect_ev("coinc_set_write", 3'b001, 1'b1, t0 + 5, 4'd7, 1'b1);
    expect_ev("coinc_clr_write", 3'b001, 1'b0, t0 + 10, 4'd7, 1'b1);
    expect_ev("coinc_done", 3'b010, 1'b0, t0 + 14, 4'd7, 1'b0);
    frame_start = 1'b1;
    accept(4'd7);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    drain(40);

    // Lock never arrives: timeout after 20 WAIT_LOCK cycles
    tx_locked = 1'b0;
    t0 = cyc;
    expect_ev("timeout_set_write", 3'b001, 1'b1, t0 + 3, 4'd9, 1'b1);
    expect_ev("timeout_clr_write", 3'b001, 1'b0, t0 + 8, 4'd9, 1'b1);
    expect_ev("timeout_err_pulse", 3'b100, 1'b0, t0 + 29, 4'd9, 1'b0);
    accept(4'd9);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (28) @(negedge clk);
    check("timeout_ready_next", {31'd0, req_ready}, 32'd1);
    check("timeout_cur_mode", {28'd0, cur_mode}, 32'd9);
    drain(10);

    // Reset asserted in HOLD: bus idles, blanking drops, INIT re-clears
    tx_locked = 1'b1;
    t0 = cyc;
    expect_ev("rst_hold_set_write", 3'b001, 1'b1, t0 + 3, 4'd2, 1'b1);
    expect_ev("rst_hold_init_clear", 3'b001, 1'b0, t0 + 6, 4'd0, 1'b0);
    accept(4'd2);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_hold_bus_idle",
          {29'd0, bus.av_chipselect, bus.av_write_n, bus.av_writedata}, {29'd0, 1'b0, 1'b1, 1'b0});
    check("rst_hold_blank", {31'd0, video_blank}, 32'd0);
    check("rst_hold_busy_ready", {30'd0, busy, req_ready}, {30'd0, 1'b1, 1'b0});
    check("rst_hold_cur_mode", {28'd0, cur_mode}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hold_ready_back", {31'd0, req_ready}, 32'd1);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
